// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor.
//   sub_state_e : controller states IDLE / RUN / DONE
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
//   in_valid/in_ready   : operand handshake (A, B, Bin)
//   out_valid/out_ready : result handshake (Diff, Bout, Ovf)
//   Ovf exists only when SERIAL_SUB_OVF_EN is defined.
//   slave  : the subtractor side
//   master : the producer/consumer side
interface serial_subtractor_if #(
    parameter int unsigned N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Bin;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Diff;
    logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         Ovf;

    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout, Ovf
    );
    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout, Ovf
    );
`else
    modport slave (
        input  in_valid, A, B, Bin, out_ready,
        output in_ready, out_valid, Diff, Bout
    );
    modport master (
        output in_valid, A, B, Bin, out_ready,
        input  in_ready, out_valid, Diff, Bout
    );
`endif
endinterface

// File: rtl/full_subtractor.sv
// One-bit combinational full subtractor: d = a - b - bin, bout = borrow out.
//   a, b, bin : minuend bit, subtrahend bit, borrow in
//   d, bout   : difference bit, borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, Diff = A - B - Bin, LSB first, one bit per clock.
//   clk, rst : clock (rising edge) and synchronous active-high reset
//   io       : serial_subtractor_if.slave operand/result handshakes
//   Optional SERIAL_SUB_OVF_EN adds the signed-overflow output io.Ovf.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  io
);
    localparam int unsigned CW = $clog2(N);

    sub_state_e    state_q;
    sub_state_e    state_d;
    logic [CW-1:0] cnt_q;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  d_sr;
    logic [N-1:0]  diff_q;
    logic          br_q;
    logic          bout_q;
    logic          d_bit;
    logic          bo_bit;
    logic          last_c;

    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (br_q),
        .d    (d_bit),
        .bout (bo_bit)
    );

    assign last_c = (cnt_q == CW'(N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io.in_valid) state_d = RUN;
            RUN:     if (last_c)      state_d = DONE;
            DONE:    if (io.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags decode straight from the state register
    assign io.in_ready  = (state_q == IDLE);
    assign io.out_valid = (state_q == DONE);

    // Datapath: operand shift registers, borrow chain, result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            br_q   <= 1'b0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        a_sr  <= io.A;
                        b_sr  <= io.B;
                        br_q  <= io.Bin;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    d_sr  <= {d_bit, d_sr[N-1:1]};
                    br_q  <= bo_bit;
                    cnt_q <= cnt_q + CW'(1);
                    // Result is published only once the last bit is known
                    if (last_c) begin
                        diff_q <= {d_bit, d_sr[N-1:1]};
                        bout_q <= bo_bit;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.Diff = diff_q;
    assign io.Bout = bout_q;

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;

    // Signed overflow: borrow into the MSB differs from borrow out of it
    always_ff @(posedge clk) begin
        if (rst)                               ovf_q <= 1'b0;
        else if ((state_q == RUN) && last_c)   ovf_q <= br_q ^ bo_bit;
    end

    assign io.Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    serial_subtractor_if #(.N(4)) bus ();

    serial_subtractor #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operand set, wait for DONE, leave result pending (out_ready=0)
    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          output logic [3:0] diff, output logic bout,
                          output logic ovf, output int lat);
        int guard;
        diff = '0; bout = 1'b0; ovf = 1'b0; lat = -1;
        bus.A = a; bus.B = b; bus.Bin = bin;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) begin
                lat = k;
                break;
            end
        end
        diff = bus.Diff;
        bout = bus.Bout;
`ifdef SERIAL_SUB_OVF_EN
        ovf = bus.Ovf;
`endif
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.A = '0; bus.B = '0; bus.Bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.Diff, bus.Bout} !== {1'b1, 1'b0, 4'h0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b diff=%h bout=%b, want rdy=1 vld=0 diff=0 bout=0",
                     bus.in_ready, bus.out_valid, bus.Diff, bus.Bout);
        end
`ifdef SERIAL_SUB_OVF_EN
        tests++;
        if (bus.Ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf: got %b want 0", bus.Ovf);
        end
`endif
    endtask

    task automatic test_basic();
        logic [3:0] d; logic bo; logic ov; int lat;
        run_op(4'd9, 4'd3, 1'b0, d, bo, ov, lat);
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL basic_latency: got %0d edges want 4", lat);
        end
        tests++;
        if ({d, bo} !== {4'h6, 1'b0}) begin
            fails++;
            $display("FAIL basic_9m3: got diff=%h bout=%b want diff=6 bout=0", d, bo);
        end
        finish_op();
    endtask

    task automatic test_borrow();
        logic [3:0] d; logic bo; logic ov; int lat;
        run_op(4'd3, 4'd9, 1'b0, d, bo, ov, lat);
        tests++;
        if ({d, bo} !== {4'hA, 1'b1} || lat !== 4) begin
            fails++;
            $display("FAIL borrow_3m9: got diff=%h bout=%b lat=%0d want diff=a bout=1 lat=4", d, bo, lat);
        end
        finish_op();
        run_op(4'd0, 4'd0, 1'b1, d, bo, ov, lat);
        tests++;
        if ({d, bo} !== {4'hF, 1'b1} || lat !== 4) begin
            fails++;
            $display("FAIL wrap_0m0m1: got diff=%h bout=%b lat=%0d want diff=f bout=1 lat=4", d, bo, lat);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        logic [3:0] d; logic bo; logic ov; int lat;
        run_op(4'd12, 4'd5, 1'b0, d, bo, ov, lat);
        tests++;
        if ({d, bo} !== {4'h7, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL bp_result: got diff=%h bout=%b lat=%0d want diff=7 bout=0 lat=4", d, bo, lat);
        end
        for (int i = 0; i < 5; i++) begin
            bus.A = 4'hF; bus.B = 4'h0; bus.Bin = 1'b1;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            tests++;
            if ({bus.out_valid, bus.in_ready, bus.Diff, bus.Bout} !== {1'b1, 1'b0, 4'h7, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b diff=%h bout=%b want vld=1 rdy=0 diff=7 bout=0",
                         i, bus.out_valid, bus.in_ready, bus.Diff, bus.Bout);
            end
        end
        finish_op();
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.Diff} !== {1'b1, 1'b0, 4'h7}) begin
            fails++;
            $display("FAIL bp_after_hs: got rdy=%b vld=%b diff=%h want rdy=1 vld=0 diff=7",
                     bus.in_ready, bus.out_valid, bus.Diff);
        end
        @(posedge clk); #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_idle_stays: got rdy=%b want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [3:0] d; logic bo; logic ov; int lat;
        bus.A = 4'd9; bus.B = 4'd3; bus.Bin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if ({bus.in_ready, bus.out_valid, bus.Diff} !== {1'b1, 1'b0, 4'h0}) begin
            fails++;
            $display("FAIL rst_mid_run: got rdy=%b vld=%b diff=%h want rdy=1 vld=0 diff=0",
                     bus.in_ready, bus.out_valid, bus.Diff);
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_partial: got vld=%b want 0", bus.out_valid);
        end
        run_op(4'd5, 4'd5, 1'b0, d, bo, ov, lat);
        tests++;
        if ({d, bo} !== {4'h0, 1'b0} || lat !== 4) begin
            fails++;
            $display("FAIL rst_then_5m5: got diff=%h bout=%b lat=%0d want diff=0 bout=0 lat=4", d, bo, lat);
        end
        finish_op();
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic [3:0] d; logic bo; logic ov; int lat;
        logic [3:0] va [3]; logic [3:0] vb [3]; logic [3:0] vd [3]; logic vo [3];
        va = '{4'd8, 4'd7, 4'd5};
        vb = '{4'd1, 4'd15, 4'd2};
        vd = '{4'd7, 4'd8, 4'd3};
        vo = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(va[i], vb[i], 1'b0, d, bo, ov, lat);
            tests++;
            if ({d, ov} !== {vd[i], vo[i]} || lat !== 4) begin
                fails++;
                $display("FAIL ovf[%0d]: got diff=%h ovf=%b lat=%0d want diff=%h ovf=%b lat=4",
                         i, d, ov, lat, vd[i], vo[i]);
            end
            finish_op();
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [3:0] ta [3]; logic [3:0] tb [3]; logic tbin [3];
        logic [3:0] ed [3]; logic eb [3];
        logic [3:0] rd [3]; logic rb [3];
        int acc [3];
        int k; int j; int cyc; logic rdy;
        ta = '{4'd9, 4'd3, 4'd0}; tb = '{4'd3, 4'd9, 4'd0}; tbin = '{1'b0, 1'b0, 1'b1};
        ed = '{4'h6, 4'hA, 4'hF}; eb = '{1'b0, 1'b1, 1'b1};
        k = 0; j = 0; cyc = 0;
        for (int i = 0; i < 3; i++) begin acc[i] = 0; rd[i] = '0; rb[i] = 1'b0; end
        bus.A = ta[0]; bus.B = tb[0]; bus.Bin = tbin[0];
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        while (j < 3 && cyc < 60) begin
            rdy = bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (rdy && bus.in_valid) begin
                acc[k] = cyc;
                k++;
                if (k < 3) begin
                    bus.A = ta[k]; bus.B = tb[k]; bus.Bin = tbin[k];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (bus.out_valid) begin
                rd[j] = bus.Diff; rb[j] = bus.Bout;
                j++;
            end
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tests++;
        if (j !== 3) begin
            fails++;
            $display("FAIL b2b_timeout: got %0d results want 3", j);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if ({rd[i], rb[i]} !== {ed[i], eb[i]}) begin
                fails++;
                $display("FAIL b2b_result[%0d]: got diff=%h bout=%b want diff=%h bout=%b",
                         i, rd[i], rb[i], ed[i], eb[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            tests++;
            if (acc[i] - acc[i-1] !== 6) begin
                fails++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles want 6", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
